// File: rtl/cache_pkg.sv
// Shared definitions for the L1 tag RAM controller: geometry, entry layout and FSM encoding.
package cache_pkg;

  localparam int IDX_W   = 7;
  localparam int TAG_W   = 22;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int WORD_W  = TAG_W + 1;
  localparam int VLD_BIT = TAG_W;

  typedef logic [WORD_W-1:0] entry_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic {
    FLUSH = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic entry_t make_entry(input logic vld, input tag_t tag);
    return {vld, tag};
  endfunction

endpackage

// File: rtl/tag_ram_ctrl_if.sv
// Request/response bundle between the cache control FSM (master) and tag_ram_ctrl (slave).
interface tag_ram_ctrl_if;
  import cache_pkg::*;

  logic lkp_valid;
  logic lkp_ready;
  idx_t lkp_idx;
  tag_t lkp_tag;

  logic rsp_valid;
  logic rsp_hit;
  tag_t rsp_tag;

  logic upd_valid;
  logic upd_ready;
  idx_t upd_idx;
  tag_t upd_tag;
  logic upd_vld;

  logic flush_req;
  logic flush_busy;
  logic flush_done;

  modport master (
    output lkp_valid, lkp_idx, lkp_tag,
    output upd_valid, upd_idx, upd_tag, upd_vld,
    output flush_req,
    input  lkp_ready, rsp_valid, rsp_hit, rsp_tag,
    input  upd_ready, flush_busy, flush_done
  );

  modport slave (
    input  lkp_valid, lkp_idx, lkp_tag,
    input  upd_valid, upd_idx, upd_tag, upd_vld,
    input  flush_req,
    output lkp_ready, rsp_valid, rsp_hit, rsp_tag,
    output upd_ready, flush_busy, flush_done
  );

endinterface

// File: rtl/ram_128_23.sv
// 128x23 1R1W tag RAM with a registered read port; a read colliding with a write
// returns the pre-write contents.
module ram_128_23
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  idx_t   raddr,
  input  logic   re,
  output entry_t rd,
  input  idx_t   waddr,
  input  entry_t wr,
  input  logic   we
);

  entry_t mem_r [ENTRIES];
  entry_t rd_r;

  // Array write port; contents are established by the controller's flush walk.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wr;
    end
  end

  // Registered read port, holds its value while re is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_r <= {WORD_W{1'b0}};
    end else if (re) begin
      rd_r <= mem_r[raddr];
    end
  end

  assign rd = rd_r;

endmodule

// File: rtl/tag_ram_ctrl.sv
// Tag RAM sequencer: flush walk after reset/on request, lookup with 1-cycle hit/miss, tag update.
// Optional macro TAG_RAM_BYPASS_EN forwards a same-cycle update to the lookup comparator.
module tag_ram_ctrl
  import cache_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  tag_ram_ctrl_if.slave  bus,
  output idx_t           ram_raddr,
  output logic           ram_re,
  output entry_t         ram_rd,
  output idx_t           ram_waddr,
  output entry_t         ram_wr,
  output logic           ram_we
);

  state_t state_r;
  state_t state_nxt_s;
  idx_t   cnt_r;
  logic   rsp_valid_r;
  tag_t   lkp_tag_r;
  logic   flush_done_r;

  logic   flush_start_s;
  logic   lkp_fire_s;
  logic   upd_fire_s;
  logic   cnt_last_s;
  entry_t cmp_word_s;

  assign cnt_last_s = (cnt_r == IDX_W'(ENTRIES - 1));
  assign lkp_fire_s = bus.lkp_valid & bus.lkp_ready;
  assign upd_fire_s = bus.upd_valid & bus.upd_ready;

  // Next state and request readiness; lookups stall as soon as flush_req is seen so
  // the one in flight can drain before the walk begins.
  always_comb begin
    state_nxt_s   = state_r;
    flush_start_s = 1'b0;
    bus.lkp_ready = 1'b0;
    bus.upd_ready = 1'b0;
    case (state_r)
      FLUSH: begin
        if (cnt_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      IDLE: begin
        if (bus.flush_req && !rsp_valid_r) begin
          flush_start_s = 1'b1;
          state_nxt_s   = FLUSH;
        end else begin
          state_nxt_s = IDLE;
        end
        bus.lkp_ready = !bus.flush_req;
        bus.upd_ready = !flush_start_s;
      end
      default: begin
        state_nxt_s = FLUSH;
      end
    endcase
  end

  // RAM port steering: flush walk owns the write port, otherwise the update request does.
  always_comb begin
    ram_re    = lkp_fire_s;
    ram_raddr = bus.lkp_idx;
    if (state_r == FLUSH) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_r;
      ram_wr    = {WORD_W{1'b0}};
    end else begin
      ram_we    = upd_fire_s;
      ram_waddr = bus.upd_idx;
      ram_wr    = make_entry(bus.upd_vld, bus.upd_tag);
    end
  end

  // FSM state, flush counter, response pipeline and flush completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= FLUSH;
      cnt_r        <= {IDX_W{1'b0}};
      rsp_valid_r  <= 1'b0;
      lkp_tag_r    <= {TAG_W{1'b0}};
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      flush_done_r <= (state_r == FLUSH) && cnt_last_s;
      rsp_valid_r  <= lkp_fire_s;
      if (flush_start_s) begin
        cnt_r <= {IDX_W{1'b0}};
      end else if (state_r == FLUSH) begin
        cnt_r <= cnt_r + IDX_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (lkp_fire_s) begin
        lkp_tag_r <= bus.lkp_tag;
      end else begin
        lkp_tag_r <= lkp_tag_r;
      end
    end
  end

`ifdef TAG_RAM_BYPASS_EN
  logic   fwd_hit_r;
  entry_t fwd_word_r;

  // Capture an update that collides with the lookup accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_hit_r  <= 1'b0;
      fwd_word_r <= {WORD_W{1'b0}};
    end else begin
      fwd_hit_r <= lkp_fire_s && upd_fire_s && (bus.lkp_idx == bus.upd_idx);
      if (upd_fire_s) begin
        fwd_word_r <= ram_wr;
      end else begin
        fwd_word_r <= fwd_word_r;
      end
    end
  end

  assign cmp_word_s = fwd_hit_r ? fwd_word_r : ram_rd;
`else
  assign cmp_word_s = ram_rd;
`endif

  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_hit    = rsp_valid_r && cmp_word_s[VLD_BIT] && (cmp_word_s[TAG_W-1:0] == lkp_tag_r);
  assign bus.rsp_tag    = rsp_valid_r ? cmp_word_s[TAG_W-1:0] : {TAG_W{1'b0}};
  assign bus.flush_busy = (state_r == FLUSH);
  assign bus.flush_done = flush_done_r;

  ram_128_23 u_ram (
    .clk   (clk),
    .rst   (rst),
    .raddr (ram_raddr),
    .re    (ram_re),
    .rd    (ram_rd),
    .waddr (ram_waddr),
    .wr    (ram_wr),
    .we    (ram_we)
  );

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Self-checking bench for tag_ram_ctrl: tag-array reference model plus scenario tasks.
module tb_tag_ram_ctrl;
  import cache_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  idx_t   ram_raddr, ram_waddr;
  logic   ram_re, ram_we;
  entry_t ram_rd, ram_wr;

  always #5 clk = ~clk;

  tag_ram_ctrl_if bus();

  tag_ram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_raddr (ram_raddr),
    .ram_re    (ram_re),
    .ram_rd    (ram_rd),
    .ram_waddr (ram_waddr),
    .ram_wr    (ram_wr),
    .ram_we    (ram_we)
  );

  entry_t model [ENTRIES];
  logic   exp_v;
  logic   exp_hit;
  tag_t   exp_tag;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic drive_idle();
    bus.lkp_valid = 1'b0; bus.lkp_idx = 7'd0; bus.lkp_tag = 22'd0;
    bus.upd_valid = 1'b0; bus.upd_idx = 7'd0; bus.upd_tag = 22'd0; bus.upd_vld = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  // Drive one cycle of requests (assumed accepted) and predict the response from the tag array.
  task automatic issue(input logic lv, input idx_t li, input tag_t lt,
                       input logic uv, input idx_t ui, input tag_t ut, input logic uvld);
    entry_t e;
    bus.lkp_valid = lv; bus.lkp_idx = li; bus.lkp_tag = lt;
    bus.upd_valid = uv; bus.upd_idx = ui; bus.upd_tag = ut; bus.upd_vld = uvld;
    e = model[li];
`ifdef TAG_RAM_BYPASS_EN
    if (uv && lv && (ui == li)) e = {uvld, ut};
`endif
    exp_v   = lv;
    exp_hit = lv && e[WORD_W-1] && (e[TAG_W-1:0] == lt);
    exp_tag = e[TAG_W-1:0];
    if (uv) model[ui] = {uvld, ut};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_hit, bus.flush_done, bus.lkp_ready, bus.upd_ready, ram_re} !== 6'b0
        || bus.rsp_tag !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b hit=%b done=%b lr=%b ur=%b re=%b tag=%h, want all 0",
               bus.rsp_valid, bus.rsp_hit, bus.flush_done, bus.lkp_ready, bus.upd_ready, ram_re, bus.rsp_tag);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < ENTRIES; k++) begin
      n_checks++;
      if ({bus.flush_busy, ram_we, ram_wr, bus.lkp_ready, bus.upd_ready, bus.flush_done}
          !== {1'b1, 1'b1, 23'h0, 1'b0, 1'b0, 1'b0} || ram_waddr !== 7'(k)) begin
        n_fail++;
        $display("FAIL flush_walk[%0d]: got busy=%b we=%b addr=%0d wr=%h lr=%b ur=%b done=%b, want busy=1 we=1 addr=%0d wr=0 lr=0 ur=0 done=0",
                 k, bus.flush_busy, ram_we, ram_waddr, ram_wr, bus.lkp_ready, bus.upd_ready, bus.flush_done, k);
      end
      @(negedge clk);
      #1;
    end
    n_checks++;
    if ({bus.flush_busy, bus.flush_done, bus.lkp_ready, bus.upd_ready} !== 4'b0111) begin
      n_fail++;
      $display("FAIL flush_end: got busy=%b done=%b lr=%b ur=%b, want 0 1 1 1",
               bus.flush_busy, bus.flush_done, bus.lkp_ready, bus.upd_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.flush_done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done_pulse: got %b, want 0", bus.flush_done);
    end
    for (int i = 0; i < ENTRIES; i++) model[i] = 23'h0;
    exp_v = 1'b0;
  endtask

  task automatic test_hit_miss();
    @(negedge clk); issue(1'b1, 7'd5, 22'h1234, 1'b0, 7'd0, 22'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0) begin
      n_fail++; $display("FAIL miss_after_flush: got v=%b hit=%b, want v=1 hit=0", bus.rsp_valid, bus.rsp_hit);
    end
    issue(1'b0, 7'd0, 22'h0, 1'b1, 7'd5, 22'h1234, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_rsp_on_update: got v=%b, want 0", bus.rsp_valid);
    end
    issue(1'b1, 7'd5, 22'h1234, 1'b0, 7'd0, 22'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.rsp_tag !== 22'h1234) begin
      n_fail++; $display("FAIL hit_1234: got v=%b hit=%b tag=%h, want v=1 hit=1 tag=1234", bus.rsp_valid, bus.rsp_hit, bus.rsp_tag);
    end
    issue(1'b1, 7'd5, 22'h1235, 1'b0, 7'd0, 22'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0 || bus.rsp_tag !== 22'h1234) begin
      n_fail++; $display("FAIL miss_1235: got v=%b hit=%b tag=%h, want v=1 hit=0 tag=1234", bus.rsp_valid, bus.rsp_hit, bus.rsp_tag);
    end
    issue(1'b0, 7'd0, 22'h0, 1'b1, 7'd5, 22'h1234, 1'b0);
    @(negedge clk);
    issue(1'b1, 7'd5, 22'h1234, 1'b0, 7'd0, 22'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0) begin
      n_fail++; $display("FAIL invalidated: got v=%b hit=%b, want v=1 hit=0", bus.rsp_valid, bus.rsp_hit);
    end
    issue(1'b0, 7'd0, 22'h0, 1'b0, 7'd0, 22'h0, 1'b0);
  endtask

  task automatic test_stream();
    int nv = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      issue(1'b0, 7'd0, 22'h0, 1'b1, 7'(i), 22'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i <= ENTRIES; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== exp_v || (exp_v && (bus.rsp_hit !== exp_hit || bus.rsp_tag !== exp_tag))) begin
        n_fail++;
        $display("FAIL stream_rsp[%0d]: got v=%b hit=%b tag=%h, want v=%b hit=%b tag=%h",
                 i, bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, exp_v, exp_hit, exp_tag);
      end
      if (bus.rsp_valid === 1'b1) nv++;
      if (i < ENTRIES)
        issue(1'b1, 7'(i), ($urandom_range(0, 1) == 1) ? model[i][TAG_W-1:0] : 22'($urandom),
              1'b0, 7'd0, 22'h0, 1'b0);
      else
        issue(1'b0, 7'd0, 22'h0, 1'b0, 7'd0, 22'h0, 1'b0);
    end
    n_checks++;
    if (nv != ENTRIES) begin
      n_fail++; $display("FAIL stream_count: got %0d responses, want %0d", nv, ENTRIES);
    end
  endtask

  task automatic test_bypass();
    logic bp_hit;
    tag_t bp_tag;
`ifdef TAG_RAM_BYPASS_EN
    bp_hit = 1'b1; bp_tag = 22'h00AB;
`else
    bp_hit = 1'b0; bp_tag = 22'h0;
`endif
    @(negedge clk); issue(1'b0, 7'd0, 22'h0, 1'b1, 7'd9, 22'h0, 1'b0);
    @(negedge clk); issue(1'b1, 7'd9, 22'h00AB, 1'b1, 7'd9, 22'h00AB, 1'b1);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== bp_hit || bus.rsp_tag !== bp_tag) begin
      n_fail++; $display("FAIL bypass_same_cycle: got v=%b hit=%b tag=%h, want v=1 hit=%b tag=%h",
                         bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, bp_hit, bp_tag);
    end
    issue(1'b1, 7'd9, 22'h00AB, 1'b0, 7'd0, 22'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.rsp_tag !== 22'h00AB) begin
      n_fail++; $display("FAIL after_write: got v=%b hit=%b tag=%h, want v=1 hit=1 tag=0000ab",
                         bus.rsp_valid, bus.rsp_hit, bus.rsp_tag);
    end
    issue(1'b0, 7'd0, 22'h0, 1'b0, 7'd0, 22'h0, 1'b0);
  endtask

  task automatic test_flush_stream();
    int   zeros = 0;
    int   dones = 0;
    int   bad = 0;
    logic seen_ready = 1'b0;
    tag_t held_tag;
    held_tag = model[3][TAG_W-1:0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== exp_v || (exp_v && (bus.rsp_hit !== exp_hit || bus.rsp_tag !== exp_tag))) begin
        n_fail++; $display("FAIL pre_flush_rsp[%0d]: got v=%b hit=%b tag=%h, want v=%b hit=%b tag=%h",
                           i, bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, exp_v, exp_hit, exp_tag);
      end
      issue(1'b1, 7'(i), model[i][TAG_W-1:0], 1'b0, 7'd0, 22'h0, 1'b0);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== exp_hit || bus.rsp_tag !== exp_tag) begin
      n_fail++; $display("FAIL pending_rsp: got v=%b hit=%b tag=%h, want v=1 hit=%b tag=%h",
                         bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, exp_hit, exp_tag);
    end
    bus.lkp_idx = 7'd3; bus.lkp_tag = held_tag; bus.flush_req = 1'b1;
    #1;
    n_checks++;
    if (bus.lkp_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_drop: got lkp_ready=%b, want 0", bus.lkp_ready);
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (bus.flush_busy === 1'b1) bus.flush_req = 1'b0;
      if (bus.flush_done === 1'b1) dones++;
      if (bus.lkp_ready === 1'b1) begin
        seen_ready = 1'b1;
        break;
      end
      zeros++;
      if (bus.rsp_valid !== 1'b0 || ram_re !== 1'b0) bad++;
    end
    n_checks++;
    if (!seen_ready || zeros != 129) begin
      n_fail++; $display("FAIL flush_stall: got %0d stalled cycles (ready seen=%b), want 129", zeros, seen_ready);
    end
    n_checks++;
    if (dones != 1 || bad != 0) begin
      n_fail++; $display("FAIL flush_quiet: got %0d done pulses, %0d stray rsp/re cycles, want 1 and 0", dones, bad);
    end
    for (int i = 0; i < ENTRIES; i++) model[i] = 23'h0;
    issue(1'b1, 7'd3, held_tag, 1'b0, 7'd0, 22'h0, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== exp_v || (exp_v && bus.rsp_hit !== 1'b0)) begin
        n_fail++; $display("FAIL post_flush_miss[%0d]: got v=%b hit=%b, want v=%b hit=0",
                           i, bus.rsp_valid, bus.rsp_hit, exp_v);
      end
      if (i < 10) issue(1'b1, 7'(i), 22'($urandom), 1'b0, 7'd0, 22'h0, 1'b0);
      else        issue(1'b0, 7'd0, 22'h0, 1'b0, 7'd0, 22'h0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== exp_v || (exp_v && (bus.rsp_hit !== exp_hit || bus.rsp_tag !== exp_tag))) begin
        n_fail++; $display("FAIL random_rsp[%0d]: got v=%b hit=%b tag=%h, want v=%b hit=%b tag=%h",
                           i, bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, exp_v, exp_hit, exp_tag);
      end
      if (i < 300) begin
        issue(1'($urandom), 7'($urandom_range(0, 7)), 22'($urandom_range(0, 3)),
              1'($urandom), 7'($urandom_range(0, 7)), 22'($urandom_range(0, 3)), 1'($urandom));
        #1;
        n_checks++;
        if (bus.lkp_ready !== 1'b1 || bus.upd_ready !== 1'b1) begin
          n_fail++; $display("FAIL random_ready[%0d]: got lr=%b ur=%b, want 1 1", i, bus.lkp_ready, bus.upd_ready);
        end
      end else begin
        issue(1'b0, 7'd0, 22'h0, 1'b0, 7'd0, 22'h0, 1'b0);
      end
    end
  endtask

  task automatic test_reflush();
    logic got_done = 1'b0;
    @(negedge clk);
    bus.flush_req = 1'b1;
    #1;
    n_checks++;
    if (bus.lkp_ready !== 1'b0 || bus.upd_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_start_ready: got lr=%b ur=%b, want 0 0", bus.lkp_ready, bus.upd_ready);
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (bus.flush_done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got_done || bus.lkp_ready !== 1'b0 || bus.flush_busy !== 1'b0) begin
      n_fail++; $display("FAIL reflush_turn: got done=%b lr=%b busy=%b, want 1 0 0", got_done, bus.lkp_ready, bus.flush_busy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.flush_busy !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== 7'd0) begin
      n_fail++; $display("FAIL reflush_start: got busy=%b we=%b addr=%0d, want 1 1 0", bus.flush_busy, ram_we, ram_waddr);
    end
    bus.flush_req = 1'b0;
    repeat (40) @(negedge clk);
    test_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_v = 1'b0; exp_hit = 1'b0; exp_tag = 22'h0;
    drive_idle();
    test_reset();
    test_hit_miss();
    test_stream();
    test_bypass();
    test_flush_stream();
    test_random();
    test_reflush();
    test_hit_miss();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
